// File: rtl/crypto_seq_ctrl.sv
// crypto_seq_ctrl: hardware sequencer for the program-1 LFSR encryption job.
// The job loads pre_len, taps and seed from the config bytes. It then walks
// the 64-byte padded message and writes byte ^ lfsr into the output region.
// Optional build macro CRYPTO_SEQ_TAP_CHECK_EN: the sequencer rejects tap
// patterns that are not in the permitted set. On a reject it raises err and
// skips straight to DONE.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  S_IDLE    | waiting for the first start after reset
//  S_LD_PRE  | mem_addr = CFG_BASE, latch pre_len
//  S_LD_TAP  | mem_addr = CFG_BASE+1, latch taps
//  S_LD_SEED | mem_addr = CFG_BASE+2, latch lfsr seed, clear byte index
//  S_FETCH   | read plaintext byte k = i - pre_len, or use 0x20 padding
//  S_STORE   | write byte ^ lfsr to OUT_BASE+i, step lfsr and index
//  S_DONE    | job finished, done high until the next start
module crypto_seq_ctrl #(
    parameter int AW         = 8,
    parameter int MSG_BASE   = 0,
    parameter int MSG_LEN    = 41,
    parameter int CFG_BASE   = 41,
    parameter int OUT_BASE   = 64,
    parameter int OUT_LEN    = 64,
    parameter int AUTO_START = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          init,
    output logic          done,
    output logic          busy,
    output logic          err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_LD_PRE, S_LD_TAP, S_LD_SEED, S_FETCH, S_STORE, S_DONE
    } state_t;

    state_t     state;
    logic       init_q;
    logic       auto_pend;
    logic       start;
    logic       tap_bad;
    logic [7:0] pre_len;
    logic [7:0] taps;
    logic [7:0] lfsr;
    logic [7:0] idx;

    // Output byte i carries plaintext k = i - pre_len when 0 <= k < MSG_LEN.
    // Unsigned compares keep large pre_len values all-padding.
    function automatic logic in_msg(input logic [7:0] i, input logic [7:0] p);
        logic [7:0] k;
        k = i - p;
        return (i >= p) && (k < 8'(MSG_LEN));
    endfunction

    function automatic logic [AW-1:0] msg_addr(input logic [7:0] i, input logic [7:0] p);
        return AW'(MSG_BASE) + AW'(i - p);
    endfunction

    assign start = (init & ~init_q) | auto_pend;

`ifdef CRYPTO_SEQ_TAP_CHECK_EN
    // Flag tap patterns outside the permitted maximal-length set.
    always_comb begin
        case (taps)
            8'he1, 8'hd4, 8'hc6, 8'hb8, 8'hb4, 8'hb2, 8'hfa, 8'hf3: tap_bad = 1'b0;
            default:                                               tap_bad = 1'b1;
        endcase
    end
`else
    assign tap_bad = 1'b0;
`endif

    // Edge detect on init, plus a one-shot start after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_q    <= 1'b0;
            auto_pend <= (AUTO_START != 0);
        end else begin
            init_q    <= init;
            auto_pend <= 1'b0;
        end
    end

    // Sequencer FSM; each output is registered for the state being entered,
    // so mem_addr is already valid when the async memory read is used.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_wr_en <= 1'b0;
            mem_wdata <= 8'h00;
            pre_len   <= 8'h00;
            taps      <= 8'h00;
            lfsr      <= 8'h00;
            idx       <= 8'h00;
        end else begin
            mem_wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_LD_PRE;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        err      <= 1'b0;
                        mem_addr <= AW'(CFG_BASE);
                    end
                end
                S_LD_PRE: begin
                    pre_len  <= mem_rdata;
                    mem_addr <= AW'(CFG_BASE + 1);
                    state    <= S_LD_TAP;
                end
                S_LD_TAP: begin
                    taps     <= mem_rdata;
                    mem_addr <= AW'(CFG_BASE + 2);
                    state    <= S_LD_SEED;
                end
                S_LD_SEED: begin
                    if (tap_bad) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        lfsr  <= mem_rdata;
                        idx   <= 8'h00;
                        state <= S_FETCH;
                        if (in_msg(8'h00, pre_len))
                            mem_addr <= msg_addr(8'h00, pre_len);
                    end
                end
                S_FETCH: begin
                    mem_wdata <= (in_msg(idx, pre_len) ? mem_rdata : 8'h20) ^ lfsr;
                    mem_wr_en <= 1'b1;
                    mem_addr  <= AW'(OUT_BASE) + AW'(idx);
                    state     <= S_STORE;
                end
                S_STORE: begin
                    lfsr <= {lfsr[6:0], ^(lfsr & taps)};
                    idx  <= idx + 8'd1;
                    if (idx == 8'(OUT_LEN - 1)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        state <= S_FETCH;
                        if (in_msg(idx + 8'd1, pre_len))
                            mem_addr <= msg_addr(idx + 8'd1, pre_len);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crypto_seq_ctrl.sv
module tb_crypto_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic       done;
    logic       busy;
    logic       err;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic [7:0]  mem [256];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_addr = 8'h00;
    logic [7:0]  bd_data = 8'h00;

    logic [7:0]  msg [41];
    logic [7:0]  exp_mem [64];
    logic [15:0] sb_q [$];
    logic [15:0] sb_e;
    int          seen [256];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    crypto_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .done      (done),
        .busy      (busy),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        else if (bd_we) mem[bd_addr] <= bd_data;
    end

    always @(negedge clk) begin
        if (busy === 1'b1) seen[mem_addr] = seen[mem_addr] + 1;
        if (reset === 1'b1) begin
            total++;
            assert (mem_wr_en === 1'b0) else begin
                bad++;
                $error("FAIL write_in_reset: observed=%0b expected=0", mem_wr_en);
            end
        end else if (mem_wr_en === 1'b1) begin
            total++;
            assert (sb_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_write: observed addr=%0h data=%0h expected no write", mem_addr, mem_wdata);
            end
            if (sb_q.size() != 0) begin
                sb_e = sb_q.pop_front();
                total++;
                assert ({mem_addr, mem_wdata} === sb_e) else begin
                    bad++;
                    $error("FAIL write_data: observed addr=%0h data=%0h expected addr=%0h data=%0h",
                           mem_addr, mem_wdata, sb_e[15:8], sb_e[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        @(posedge clk);
        #1;
        bd_we   = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model of one job: padded message XOR running LFSR.
    task automatic push_job(input logic [7:0] pre, input logic [7:0] tp, input logic [7:0] sd);
        logic [7:0] l;
        logic [7:0] b;
        int         k;
        l = sd;
        for (int i = 0; i < 64; i++) begin
            k = i - int'(pre);
            b = 8'h20;
            if (k >= 0 && k < 41) b = msg[k];
            exp_mem[i] = b ^ l;
            sb_q.push_back({8'(64 + i), b ^ l});
            l = {l[6:0], ^(l & tp)};
        end
    endtask

    task automatic load_cfg(input logic [7:0] pre, input logic [7:0] tp, input logic [7:0] sd);
        bd_write(8'd41, pre);
        bd_write(8'd42, tp);
        bd_write(8'd43, sd);
    endtask

    task automatic start_pulse();
        init = 1'b1;
        tick();
        cyc  = 0;
        init = 1'b0;
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && cyc < 400) tick();
    endtask

    initial begin
        string      s;
        logic [7:0] seed;
        logic [7:0] snap [64];
        int         seen_snap [41];
        int         diffs;

        s = "Mr. Watson, come here. I want to see you.";
        for (int i = 0; i < 41; i++) msg[i] = s[i];
        for (int i = 0; i < 256; i++) seen[i] = 0;

        // Reset state and memory preload while held in reset.
        reset = 1'b1;
        init  = 1'b0;
        repeat (2) tick();
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        for (int i = 0; i < 41; i++) bd_write(8'(i), msg[i]);
        load_cfg(8'd9, 8'hd4, 8'h01);

        // 1: basic encryption through auto start.
        push_job(8'd9, 8'hd4, 8'h01);
        reset = 1'b0;
        tick();
        cyc = 0;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_done_low", {31'd0, done}, 32'd0);
        wait_done();
        chk("t1_latency", cyc, 32'd131);
        chk("t1_mem64", {24'd0, mem[64]}, 32'h21);
        chk("t1_mem65", {24'd0, mem[65]}, 32'h22);
        chk("t1_sb_empty", sb_q.size(), 32'd0);
        chk("t1_err", {31'd0, err}, 32'd0);

        // 2: rerun via a two-clock init pulse with a random seed.
        seed = 8'($urandom_range(0, 255));
        load_cfg(8'd11, 8'hb2, seed);
        push_job(8'd11, 8'hb2, seed);
        init = 1'b1;
        tick();
        cyc = 0;
        chk("t2_done_drop", {31'd0, done}, 32'd0);
        tick();
        init = 1'b0;
        wait_done();
        chk("t2_latency", cyc, 32'd131);
        repeat (10) tick();
        chk("t2_done_hold", {31'd0, done}, 32'd1);
        chk("t2_busy_idle", {31'd0, busy}, 32'd0);
        chk("t2_sb_empty", sb_q.size(), 32'd0);

        // 3a: pre_len = 0 with init held high for the whole job.
        seed = 8'($urandom_range(0, 255));
        load_cfg(8'd0, 8'he1, seed);
        push_job(8'd0, 8'he1, seed);
        init = 1'b1;
        tick();
        cyc = 0;
        wait_done();
        chk("t3a_latency", cyc, 32'd131);
        repeat (10) tick();
        chk("t3a_no_retrigger", {31'd0, done}, 32'd1);
        init = 1'b0;
        chk("t3a_mem64", {24'd0, mem[64]}, {24'd0, 8'h4d ^ seed});
        chk("t3a_mem105", {24'd0, mem[105]}, {24'd0, exp_mem[41]});
        chk("t3a_mem127", {24'd0, mem[127]}, {24'd0, exp_mem[63]});
        chk("t3a_sb_empty", sb_q.size(), 32'd0);

        // 3b: pre_len = 30 truncates the message after msg[33].
        load_cfg(8'd30, 8'hc6, 8'h5a);
        push_job(8'd30, 8'hc6, 8'h5a);
        for (int i = 0; i < 41; i++) seen_snap[i] = seen[i];
        start_pulse();
        wait_done();
        chk("t3b_latency", cyc, 32'd131);
        for (int i = 34; i < 41; i++) chk("t3b_not_addressed", seen[i], seen_snap[i]);
        chk("t3b_msg33_read", {31'd0, seen[33] > seen_snap[33]}, 32'd1);
        chk("t3b_mem127", {24'd0, mem[127]}, {24'd0, exp_mem[63]});
        chk("t3b_sb_empty", sb_q.size(), 32'd0);

        // 4a: init pulse while busy is ignored.
        load_cfg(8'd9, 8'hb8, 8'h3c);
        push_job(8'd9, 8'hb8, 8'h3c);
        start_pulse();
        while (cyc < 40) tick();
        init = 1'b1;
        tick();
        init = 1'b0;
        wait_done();
        chk("t4_busy_init_latency", cyc, 32'd131);
        chk("t4_sb_empty", sb_q.size(), 32'd0);

        // 4b: reset mid-job aborts; auto start reruns the job after release.
        push_job(8'd9, 8'hb8, 8'h3c);
        start_pulse();
        while (cyc < 50) tick();
        reset = 1'b1;
        #1;
        chk("t4_abort_done", {31'd0, done}, 32'd0);
        chk("t4_abort_busy", {31'd0, busy}, 32'd0);
        chk("t4_abort_wr_en", {31'd0, mem_wr_en}, 32'd0);
        sb_q.delete();
        repeat (3) tick();
        push_job(8'd9, 8'hb8, 8'h3c);
        reset = 1'b0;
        tick();
        cyc = 0;
        chk("t4_restart_busy", {31'd0, busy}, 32'd1);
        wait_done();
        chk("t4_restart_latency", cyc, 32'd131);
        chk("t4_restart_sb_empty", sb_q.size(), 32'd0);

        // 5: illegal tap pattern.
        bd_write(8'd42, 8'h55);
        for (int i = 0; i < 64; i++) snap[i] = mem[64 + i];
`ifdef CRYPTO_SEQ_TAP_CHECK_EN
        start_pulse();
        wait_done();
        chk("t5_tap_latency", cyc, 32'd3);
        chk("t5_tap_err", {31'd0, err}, 32'd1);
        diffs = 0;
        for (int i = 0; i < 64; i++) if (mem[64 + i] !== snap[i]) diffs++;
        chk("t5_out_unchanged", diffs, 32'd0);
        bd_write(8'd42, 8'hf3);
        push_job(8'd9, 8'hf3, 8'h3c);
        start_pulse();
        chk("t5_err_clear", {31'd0, err}, 32'd0);
        wait_done();
        chk("t5_rerun_latency", cyc, 32'd131);
`else
        push_job(8'd9, 8'h55, 8'h3c);
        start_pulse();
        wait_done();
        chk("t5_tap_latency", cyc, 32'd131);
        chk("t5_tap_err", {31'd0, err}, 32'd0);
        diffs = 0;
        for (int i = 0; i < 64; i++) if (mem[64 + i] !== exp_mem[i]) diffs++;
        chk("t5_out_model", diffs, 32'd0);
`endif
        chk("t5_sb_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
